// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Framing bytes shared with the RX decoder, frame size limit and FSM encodings
// used by the UART tx frame arbiter and its byte sender.
package uart_tx_frame_arbiter_pkg;

  localparam int         MAXBYTES = 4;
  localparam logic [7:0] SP_SYNC  = 8'h7E;
  localparam logic [7:0] SP_ESC   = 8'hFE;
  localparam logic [7:0] SP_END   = 8'h03;

  typedef enum logic [2:0] {IDLE, SYNC, BCNT, DATA, ESC, END, DONE} frameState_t;

  typedef enum logic [1:0] {S_IDLE, LOAD, WAIT_BUSY, WAIT_DONE} sendState_t;

endpackage

// File: rtl/uart_tx_byte_sender.sv
// One-byte UART handshake: ld_tx_data the cycle after start, then wait for tx_empty low/high.
// done when tx_empty returns; tout if the wait exceeds TX_TOUT cycles.
module uart_tx_byte_sender #(
  parameter int TX_TOUT = 1000
) (
  input  logic       ct_rxclk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] txByte,
  output logic       done,
  output logic       tout,
  input  logic       tx_empty,
  output logic       ld_tx_data,
  output logic [7:0] tx_data
);
  import uart_tx_frame_arbiter_pkg::*;

  localparam int CW = $clog2(TX_TOUT + 1);

  sendState_t    state, stateNext;
  logic [CW-1:0] cnt;
  logic [7:0]    byteReg;
  logic          cntLast;

  assign cntLast = (cnt == CW'(TX_TOUT - 1));

  always_comb begin
    stateNext = state;
    done      = 1'b0;
    tout      = 1'b0;
    case (state)
      S_IDLE:    if (start) stateNext = LOAD;
      LOAD:      stateNext = WAIT_BUSY;
      WAIT_BUSY: begin
        if (cntLast) begin
          tout      = 1'b1;
          stateNext = S_IDLE;
        end else if (!tx_empty) begin
          stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_empty) begin
          done      = 1'b1;
          stateNext = S_IDLE;
        end else if (cntLast) begin
          tout      = 1'b1;
          stateNext = S_IDLE;
        end
      end
      default:   stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      byteReg <= '0;
    end else begin
      state <= stateNext;
      if (state == S_IDLE && start) byteReg <= txByte;
      // Budget covers both wait phases of one byte.
      if (state == LOAD) cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE) cnt <= cnt + CW'(1);
    end
  end

  assign ld_tx_data = (state == LOAD);
  assign tx_data    = ld_tx_data ? byteReg : 8'h00;

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one UART tx between two requesters, framing each message as SYNC,BCNT,escaped data,END.
// First load two cycles after a sampled request; each byte waits on tx_empty, aborting after TX_TOUT.
module uart_tx_frame_arbiter #(
  parameter int         MAXBYTES = uart_tx_frame_arbiter_pkg::MAXBYTES,
  parameter int         TX_TOUT  = 1000,
  parameter logic [7:0] SP_SYNC  = uart_tx_frame_arbiter_pkg::SP_SYNC,
  parameter logic [7:0] SP_ESC   = uart_tx_frame_arbiter_pkg::SP_ESC,
  parameter logic [7:0] SP_END   = uart_tx_frame_arbiter_pkg::SP_END
) (
  input  logic                  ct_rxclk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [8*MAXBYTES-1:0] msg0,
  input  logic [2:0]            len0,
  input  logic [8*MAXBYTES-1:0] msg1,
  input  logic [2:0]            len1,
  output logic [1:0]            ack,
  output logic                  err,
  input  logic                  tx_empty,
  output logic                  ld_tx_data,
  output logic [7:0]            tx_data,
  output logic                  tx_enable,
  output logic                  busy,
  output logic                  grant
);
  import uart_tx_frame_arbiter_pkg::*;

  frameState_t           state, stateNext;
  logic                  gnt, lastGrant, errReg, inFlight;
  logic [8*MAXBYTES-1:0] msgSh;
  logic [2:0]            lenReg, idx, selLen;
  logic                  gSel, grantNow, lenBad, lastByte, emitting;
  logic                  curSpecial, nextSpecial;
  logic [7:0]            curByte, nextByte, txByte;
  logic                  start, done, tout;

  always_comb begin
    gSel = 1'b0;
    if (req == 2'b10)      gSel = 1'b1;
    else if (req == 2'b11) gSel = ~lastGrant;
  end

  assign grantNow    = (state == IDLE) && tx_empty && (req != 2'b00);
  assign selLen      = gSel ? len1 : len0;
  assign lenBad      = (selLen == 3'd0) || (int'(selLen) > MAXBYTES);
  assign curByte     = msgSh[8*MAXBYTES-1 -: 8];
  assign nextByte    = msgSh[8*MAXBYTES-9 -: 8];
  assign curSpecial  = (curByte == SP_SYNC) || (curByte == SP_ESC);
  assign nextSpecial = (nextByte == SP_SYNC) || (nextByte == SP_ESC);
  assign lastByte    = (idx == lenReg - 3'd1);
  assign emitting    = state inside {SYNC, BCNT, ESC, DATA, END};
  assign start       = emitting && !inFlight;

  always_comb begin
    stateNext = state;
    txByte    = 8'h00;
    case (state)
      IDLE: if (grantNow) stateNext = lenBad ? DONE : SYNC;
      SYNC: begin
        txByte = SP_SYNC;
        if (done) stateNext = BCNT;
      end
      BCNT: begin
        txByte = {5'b0, lenReg};
        if (done) stateNext = curSpecial ? ESC : DATA;
      end
      ESC: begin
        txByte = SP_ESC;
        if (done) stateNext = DATA;
      end
      DATA: begin
        txByte = curByte;
        if (done) stateNext = lastByte ? END : (nextSpecial ? ESC : DATA);
      end
      END: begin
        txByte = SP_END;
        if (done) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (tout) stateNext = DONE;
  end

  always_ff @(posedge ct_rxclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      lastGrant <= 1'b1;
      msgSh     <= '0;
      lenReg    <= '0;
      idx       <= '0;
      errReg    <= 1'b0;
      inFlight  <= 1'b0;
    end else begin
      state <= stateNext;
      if (start) inFlight <= 1'b1;
      else if (done || tout) inFlight <= 1'b0;
      if (grantNow) begin
        gnt       <= gSel;
        lastGrant <= gSel;
        msgSh     <= gSel ? msg1 : msg0;
        lenReg    <= selLen;
        idx       <= '0;
        errReg    <= lenBad;
      end
      if (tout) errReg <= 1'b1;
      // Shift the payload so the current data byte is always at the top.
      if (state == DATA && done && !lastByte) begin
        idx   <= idx + 3'd1;
        msgSh <= msgSh << 8;
      end
    end
  end

  uart_tx_byte_sender #(.TX_TOUT(TX_TOUT)) u_sender (
    .ct_rxclk   (ct_rxclk),
    .reset      (reset),
    .start      (start),
    .txByte     (txByte),
    .done       (done),
    .tout       (tout),
    .tx_empty   (tx_empty),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data)
  );

  assign ack       = (state == DONE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign err       = (state == DONE) && errReg;
  assign busy      = (state != IDLE) && (state != DONE);
  assign tx_enable = busy;
  assign grant     = gnt;

endmodule
